// File: rtl/cpu_core_p_if.sv
// Data-memory/peripheral bus of cpu_core_p: request/acknowledge handshake
// with an arbitrary number of wait states.
interface cpu_core_p_if #(
  parameter int DATA_W  = 32,
  parameter int DADDR_W = 16
);
  logic [DADDR_W-1:0] dataAddress;
  logic [DATA_W-1:0]  dataOut;
  logic               dataWrEn;
  logic               dataReq;
  logic               dataAck;
  logic [DATA_W-1:0]  dataIn;

  modport master (
    output dataAddress, dataOut, dataWrEn, dataReq,
    input  dataAck, dataIn
  );

  modport slave (
    input  dataAddress, dataOut, dataWrEn, dataReq,
    output dataAck, dataIn
  );
endinterface

// File: rtl/cpu_core_p.sv
// Single-issue load/store core with conditional writeback, flags Z/C/GE and a
// req/ack data bus; register index 14 aliases the PC and 15 the overflow register.
module cpu_core_p #(
  parameter int DATA_W  = 32,
  parameter int IADDR_W = 12,
  parameter int DADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instructionIn,
  output logic [IADDR_W-1:0] instructionAddress,
  cpu_core_p_if.master       bus,
  output logic [7:0]         cpuStatus
);
  localparam int SH_W = $clog2(DATA_W);

  localparam logic [4:0] OP_LOAD  = 5'h01;
  localparam logic [4:0] OP_STORE = 5'h02;
  localparam logic [4:0] OP_HALT  = 5'h03;
  localparam logic [4:0] OP_SHL   = 5'h08;
  localparam logic [4:0] OP_SHR   = 5'h09;
  localparam logic [4:0] OP_SRA   = 5'h0A;
  localparam logic [4:0] OP_AND   = 5'h0D;
  localparam logic [4:0] OP_OR    = 5'h0E;
  localparam logic [4:0] OP_XOR   = 5'h0F;
  localparam logic [4:0] OP_ADD   = 5'h10;
  localparam logic [4:0] OP_ADDC  = 5'h11;
  localparam logic [4:0] OP_SUB   = 5'h12;

  typedef enum logic [1:0] {EXEC, MEM_WAIT, HALTED} state_t;

  state_t             state_q, state_d;
  logic [IADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0]  regs_q [14];
  logic [DATA_W-1:0]  regs_d [14];
  logic [DATA_W-1:0]  ovf_q, ovf_d;
  logic               z_q, z_d, c_q, c_d, ge_q, ge_d;
  logic               req_q, req_d, wr_q, wr_d;
  logic [DADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic [3:0]         mem_rc_q, mem_rc_d;
  logic [7:0]         status_q, status_d;

  logic              imb, cmp;
  logic [3:0]        ra, rb, rc;
  logic [13:0]       imm;
  logic [4:0]        opc;
  logic [2:0]        cond;

  assign imb  = instructionIn[31];
  assign ra   = instructionIn[30:27];
  assign rb   = instructionIn[26:23];
  assign imm  = instructionIn[26:13];
  assign opc  = instructionIn[12:8];
  assign rc   = instructionIn[7:4];
  assign cond = instructionIn[3:1];
  assign cmp  = instructionIn[0];

  logic [DATA_W-1:0] op_a, op_b, rb_val, rc_val;

  // Operand read ports; index 14 reads the zero-extended PC, 15 the overflow register.
  always_comb begin
    op_a   = ovf_q;
    rb_val = ovf_q;
    rc_val = ovf_q;
    if (ra < 4'd14)       op_a = regs_q[ra];
    else if (ra == 4'd14) op_a = DATA_W'(pc_q);
    if (rb < 4'd14)       rb_val = regs_q[rb];
    else if (rb == 4'd14) rb_val = DATA_W'(pc_q);
    if (rc < 4'd14)       rc_val = regs_q[rc];
    else if (rc == 4'd14) rc_val = DATA_W'(pc_q);
    op_b = imb ? {{(DATA_W-14){imm[13]}}, imm} : rb_val;
  end

  logic [DATA_W:0]   sum_add, sum_sub;
  logic [SH_W-1:0]   sh_amt;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_ge, is_alu, cond_true;

  always_comb begin
    sum_add = {1'b0, op_a} + {1'b0, op_b} + (DATA_W+1)'((opc == OP_ADDC) ? c_q : 1'b0);
    sum_sub = {1'b0, op_a} + {1'b0, ~op_b} + (DATA_W+1)'(1);
    sh_amt  = op_b[SH_W-1:0];
    // GE is signed A >= B taken from A-B, whatever the opcode.
    alu_ge  = ~(sum_sub[DATA_W-1] ^
                ((op_a[DATA_W-1] ^ op_b[DATA_W-1]) & (sum_sub[DATA_W-1] ^ op_a[DATA_W-1])));
    alu_res = '0;
    alu_c   = 1'b0;
    is_alu  = 1'b1;
    case (opc)
      OP_SHL:  alu_res = op_a << sh_amt;
      OP_SHR:  alu_res = op_a >> sh_amt;
      OP_SRA:  alu_res = DATA_W'($signed(op_a) >>> sh_amt);
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_ADD, OP_ADDC: begin
        alu_res = sum_add[DATA_W-1:0];
        alu_c   = sum_add[DATA_W];
      end
      OP_SUB: begin
        alu_res = sum_sub[DATA_W-1:0];
        alu_c   = sum_sub[DATA_W];
      end
      default: is_alu = 1'b0;
    endcase
  end

  always_comb begin
    case (cond)
      3'd1:    cond_true = 1'b0;
      3'd2:    cond_true = z_q;
      3'd3:    cond_true = ~z_q;
      3'd4:    cond_true = ge_q;
      3'd5:    cond_true = ~ge_q;
      default: cond_true = 1'b1;
    endcase
  end

  logic              wb_en, advance;
  logic [3:0]        wb_idx;
  logic [DATA_W-1:0] wb_val;

  // Next-state logic; a writeback to index 14 overrides the normal PC+1.
  always_comb begin
    state_d  = state_q;
    regs_d   = regs_q;
    ovf_d    = ovf_q;
    z_d      = z_q;
    c_d      = c_q;
    ge_d     = ge_q;
    req_d    = req_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    mem_rc_d = mem_rc_q;
    wb_en    = 1'b0;
    wb_idx   = rc;
    wb_val   = alu_res;
    advance  = 1'b0;

    case (state_q)
      EXEC: begin
        advance = 1'b1;
        if (is_alu) begin
          if (cmp) begin
            z_d  = (alu_res == '0);
            c_d  = alu_c;
            ge_d = alu_ge;
          end
          wb_en = cond_true;
        end else if ((opc == OP_LOAD || opc == OP_STORE) && cond_true) begin
          advance  = 1'b0;
          req_d    = 1'b1;
          wr_d     = (opc == OP_STORE);
          addr_d   = sum_add[DADDR_W-1:0];
          mem_rc_d = rc;
          if (opc == OP_STORE) dout_d = rc_val;
          state_d  = MEM_WAIT;
        end else if (opc == OP_HALT && cond_true) begin
          advance = 1'b0;
          state_d = HALTED;
        end
      end
      MEM_WAIT: begin
        if (bus.dataAck) begin
          req_d   = 1'b0;
          state_d = EXEC;
          advance = 1'b1;
          wb_en   = ~wr_q;
          wb_idx  = mem_rc_q;
          wb_val  = bus.dataIn;
        end
      end
      default: ;
    endcase

    pc_d = advance ? pc_q + IADDR_W'(1) : pc_q;
    if (wb_en) begin
      if (wb_idx < 4'd14)       regs_d[wb_idx] = wb_val;
      else if (wb_idx == 4'd15) ovf_d = wb_val;
      else                      pc_d = wb_val[IADDR_W-1:0];
    end

    case (state_d)
      MEM_WAIT: status_d = 8'h02;
      HALTED:   status_d = 8'h01;
      default:  status_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EXEC;
      pc_q     <= '0;
      for (int i = 0; i < 14; i++) regs_q[i] <= '0;
      ovf_q    <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      ge_q     <= 1'b0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      mem_rc_q <= '0;
      status_q <= 8'hA0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      regs_q   <= regs_d;
      ovf_q    <= ovf_d;
      z_q      <= z_d;
      c_q      <= c_d;
      ge_q     <= ge_d;
      req_q    <= req_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      mem_rc_q <= mem_rc_d;
      status_q <= status_d;
    end
  end

  assign instructionAddress = pc_q;
  assign bus.dataAddress    = addr_q;
  assign bus.dataOut        = dout_q;
  assign bus.dataWrEn       = wr_q;
  assign bus.dataReq        = req_q;
  assign cpuStatus          = status_q;
endmodule

// File: doc/cpu_core_p.md
# cpu_core_p

Parametrised single-issue CPU core, the next generation of the team's 32-bit load/store core. It keeps the existing 32-bit instruction encoding and conditional-writeback model, and generalises data and address widths. New relative to the previous core: a request/acknowledge data-bus handshake with arbitrary wait states, an integrated ALU with shifts, a HALT instruction, and defined behaviour for untaken writes to the PC. It sits between the instruction ROM (combinational read) and the data-memory/peripheral bus.

## Interface
- DATA_W, 32, datapath and register width; legal range 16..64
- IADDR_W, 12, instruction address width; must be ≤ DATA_W
- DADDR_W, 16, data address width; must be ≤ DATA_W
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  one clock; reset is synchronous and active-high
- instructionIn  in  32  instruction at instructionAddress, valid same cycle
- instructionAddress  out  IADDR_W  current PC
- dataAddress  out  DADDR_W  bus address, held while dataReq=1
- dataOut  out  DATA_W  store data, held while dataReq=1
- dataWrEn  out  1  1 = store, 0 = load; held while dataReq=1
- dataReq  out  1  bus request
- dataAck  in  1  bus completion; sampled only while dataReq=1
- dataIn  in  DATA_W  load data, valid when dataAck=1
- cpuStatus  out  8  0xA0 in reset, 0x00 running, 0x02 bus wait, 0x01 halted

## Operation
- Instruction fields:
  - Imb=[31], Ra=[30:27], Rb=[26:23], Imm=[26:13], Opc=[12:8], Rc=[7:4], Cond=[3:1], Cmp=[0].
  - Imm is sign-extended from bit 13 to DATA_W.
- Registers r0..r13 are general-purpose. Index 14 is the PC (zero-extended on read). Index 15 is the overflow register. This mapping applies to Ra, Rb (when Imb=0) and Rc.
- A = reg[Ra]. B = Imb ? sext(Imm) : reg[Rb].
- Opcodes:
  - LOAD 0x01, STORE 0x02, HALT 0x03.
  - SHL 0x08, SHR 0x09 (logical), SRA 0x0A; shift amount is B[log2(DATA_W)-1:0].
  - AND 0x0D, OR 0x0E, XOR 0x0F.
  - ADD 0x10, ADDC 0x11 (A+B+C), SUB 0x12 (A-B).
  - All other opcodes are NOPs: no writeback, no flag update, PC+1.
- Flags Z/C/GE are updated only when Cmp=1 and Opc is an ALU op; the flag update does not depend on Cond.
  - Z: result == 0.
  - C: carry out for ADD/ADDC; not-borrow for SUB; 0 for logic/shift ops.
  - GE: signed A ≥ B, computed as N xor V == 0 on A-B for every ALU op.
- Conditions (evaluated on the flags before this instruction's update):
  - 0 always, 1 never, 2 Z, 3 !Z, 4 GE, 5 !GE, 6/7 always.
- ALU op, condition true:
  - Rc<14: reg[Rc] ← result.
  - Rc=15: overflow ← result.
  - Rc=14: PC ← result[IADDR_W-1:0], with no +1.
  - In all other cases PC ← PC+1, including Rc=14 with the condition false.
- LOAD/STORE:
  - Address = (A+B)[DADDR_W-1:0].
  - STORE data = reg[Rc].
  - Condition false: no bus cycle, PC+1.
- HALT, condition true: enter HALTED. Condition false: NOP.

## Timing
- States: EXEC, MEM_WAIT, HALTED.
- Reset, when rst=1 at an edge:
  - PC=0, r0..r13=0, overflow=0, flags=0.
  - dataReq=0, dataWrEn=0, dataAddress=0, dataOut=0, cpuStatus=0xA0.
  - State EXEC.
  - An in-flight bus request is dropped on that same edge.
- EXEC, ALU op or NOP: completes in 1 cycle.
- EXEC, taken LOAD/STORE:
  - Edge: dataReq←1, address/data/WrEn registered, state MEM_WAIT, cpuStatus 0x02.
  - PC is not advanced.
- MEM_WAIT:
  - dataAck=0: hold all bus outputs and the PC.
  - dataAck=1 at an edge: dataReq←0, state EXEC, cpuStatus 0x00.
  - LOAD completion writes dataIn to Rc, using the PC/overflow rules above (Rc=14 loads the PC, no +1). Otherwise PC+1.
  - Minimum load/store latency is 2 cycles.
  - A load result is visible to the next instruction.
  - dataAck while dataReq=0 is ignored.
- HALTED: PC, registers and bus outputs frozen, dataReq=0, cpuStatus 0x01. Only rst exits.
- cpuStatus becomes 0x00 on the first edge after reset deasserts.
- PC wraps from 2^IADDR_W-1 to 0. Address and ALU arithmetic are modulo 2^width.

## Test plan
- Reset, then ADD r1 = r0 + imm 5 with Cmp=1:
  - r1=5, Z=0, PC=1 after one cycle.
  - cpuStatus 0xA0 during reset, 0x00 after.
- SUB r2 = r1 - imm 5, Cmp=1, then ADD Rc=14 Cond=ZERO imm 0x40:
  - PC=0x40.
  - Repeat with Cond=NOTZERO: PC advances by 1 (no lock-up).
- LOAD r3 from address 0x10 with dataAck delayed 3 cycles, dataIn=0xDEADBEEF:
  - dataReq high for 4 cycles with dataAddress=0x10, dataWrEn=0.
  - r3=0xDEADBEEF, PC+1 only at the ack edge.
- STORE r3 to 0x20 with Cond=NEVER: no dataReq, PC+1.
  - Same STORE with Cond=ALWAYS and ack in the first wait cycle: dataOut=0xDEADBEEF, dataWrEn=1, 2-cycle instruction.
- ADD 0xFFFFFFFF + 1 with Cmp=1, then ADDC r4 = r0 + 0:
  - First instruction gives Z=1, C=1.
  - r4=1.
  - SRA of 0x80000000 by 4 gives 0xF8000000.
- Assert rst during MEM_WAIT: dataReq=0 on that edge, PC=0.
  - HALT: PC frozen for 10 cycles, cpuStatus 0x01.
